rom_rr_arbiter: RTL and testbench

Two-port round-robin arbiter and read sequencer that shares one combinational ROM (AW-bit address in, DW-bit data out) between two requesters. Each requester issues an address with a req/gnt handshake and receives registered read data with an rvalid/rready handshake. The block drives the ROM address from a register and captures ROM data one cycle later. It sits between client logic and the single ROM instance.

---
 rtl/rom_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_rom_rr_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_rr_arbiter.sv
// Two-port round-robin arbiter and read sequencer sharing one combinational ROM.
// All outputs are registered; one read completes every three cycles at best.
module rom_rr_arbiter #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          rready0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    input  logic          rready1,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_dout,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, GRANT, RESP} state_e;

    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          busy_q, busy_d;
    logic          choice;
    logic          rready_sel;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        rom_addr_d = rom_addr_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        rvalid0_d  = rvalid0_q;
        rvalid1_d  = rvalid1_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        choice     = 1'b0;
        rready_sel = sel_q ? rready1 : rready0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // last only breaks ties; a lone requester always wins
                    choice     = (req0 && req1) ? ~last_q : req1;
                    sel_d      = choice;
                    rom_addr_d = choice ? addr1 : addr0;
                    gnt0_d     = ~choice;
                    gnt1_d     = choice;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (sel_q) begin
                    rdata1_d  = rom_dout;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = rom_dout;
                    rvalid0_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rready_sel) begin
                    rvalid0_d = 1'b0;
                    rvalid1_d = 1'b0;
                    last_d    = sel_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;
            rom_addr_q <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            rom_addr_q <= rom_addr_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign rom_addr = rom_addr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Directed self-checking bench for rom_rr_arbiter with a constant 8-entry ROM.
module tb_rom_rr_arbiter;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 16;

    localparam logic [DW-1:0] ROM [8] = '{
        16'h1A00, 16'h2B11, 16'h3C22, 16'h4D33,
        16'h5E44, 16'h6F55, 16'h7066, 16'h8177
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          rready0 = 1'b1, rready1 = 1'b1;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [DW-1:0] rdata0, rdata1, rom_dout;
    logic [AW-1:0] rom_addr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int g_first, g_second;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rom_dout = ROM[rom_addr];

    rom_rr_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .rready0(rready0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .rready1(rready1),
        .rom_addr(rom_addr), .rom_dout(rom_dout), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        rready0 = 1'b1;
        rready1 = 1'b1;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        #2;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rvalid1", rvalid1, 0);
        check("rst_busy", busy, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_rdata0", rdata0, 0);
        do_reset();

        // Single read on port 0
        req0 = 1'b1; addr0 = 3'h5;
        step();
        check("s_gnt0", gnt0, 1);
        check("s_gnt1", gnt1, 0);
        check("s_rom_addr", rom_addr, 5);
        check("s_busy", busy, 1);
        req0 = 1'b0;
        step();
        check("s_gnt0_drop", gnt0, 0);
        check("s_rvalid0", rvalid0, 1);
        check("s_rdata0", rdata0, 16'h6F55);
        check("s_rvalid1", rvalid1, 0);
        step();
        check("s_rvalid0_drop", rvalid0, 0);
        check("s_busy_idle", busy, 0);
        check("s_rdata0_hold", rdata0, 16'h6F55);

        // Contention right after reset: port 0 wins
        do_reset();
        req0 = 1'b1; addr0 = 3'h2;
        req1 = 1'b1; addr1 = 3'h7;
        step();
        g_first = cyc;
        check("c_gnt0", gnt0, 1);
        check("c_gnt1", gnt1, 0);
        req0 = 1'b0;
        step();
        check("c_rdata0", rdata0, 16'h3C22);
        check("c_rvalid0", rvalid0, 1);
        step();
        check("c_rvalid0_drop", rvalid0, 0);
        check("c_gnt1_wait", gnt1, 0);
        step();
        g_second = cyc;
        check("c_gnt1", gnt1, 1);
        check("c_rom_addr", rom_addr, 7);
        check("c_gap", g_second - g_first, 3);
        req1 = 1'b0;
        step();
        check("c_rvalid1", rvalid1, 1);
        check("c_rdata1", rdata1, 16'h8177);
        step();
        check("c_rvalid1_drop", rvalid1, 0);

        // Fairness: both hold req, grants alternate starting with port 0
        req0 = 1'b1; req1 = 1'b1;
        for (int t = 0; t < 6; t++) begin
            addr0 = 3'(t);
            addr1 = 3'(7 - t);
            step();
            check("f_gnt0", gnt0, (t % 2 == 0) ? 1 : 0);
            check("f_gnt1", gnt1, (t % 2 == 1) ? 1 : 0);
            step();
            if (t % 2 == 0) check("f_rdata0", rdata0, ROM[t]);
            else            check("f_rdata1", rdata1, ROM[7 - t]);
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        check("f_idle", busy, 0);

        // Backpressure on port 1 with port 0 waiting
        rready1 = 1'b0;
        req1 = 1'b1; addr1 = 3'h3;
        step();
        check("b_gnt1", gnt1, 1);
        req1 = 1'b0;
        step();
        req0 = 1'b1; addr0 = 3'h6;
        for (int i = 0; i < 5; i++) begin
            check("b_rvalid1", rvalid1, 1);
            check("b_rdata1", rdata1, 16'h4D33);
            check("b_gnt0", gnt0, 0);
            if (i < 4) step();
        end
        rready1 = 1'b1;
        step();
        check("b_rvalid1_drop", rvalid1, 0);
        check("b_gnt0_late", gnt0, 0);
        step();
        check("b_gnt0", gnt0, 1);
        req0 = 1'b0;
        step();
        check("b_rdata0", rdata0, 16'h7066);
        step();

        // Full sweep on port 1
        for (int a = 0; a < 8; a++) begin
            req1 = 1'b1; addr1 = 3'(a);
            step();
            check("w_gnt1", gnt1, 1);
            check("w_busy", busy, 1);
            step();
            check("w_rvalid1", rvalid1, 1);
            check("w_rdata1", rdata1, ROM[a]);
            if (a == 7) req1 = 1'b0;
            step();
            check("w_busy_gap", busy, 0);
        end

        // Asynchronous reset during RESP
        rready0 = 1'b0;
        req0 = 1'b1; addr0 = 3'h4;
        step();
        req0 = 1'b0;
        step();
        check("r_rvalid0_pre", rvalid0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_rvalid0", rvalid0, 0);
        check("r_gnt0", gnt0, 0);
        check("r_busy", busy, 0);
        check("r_rdata0", rdata0, 0);
        check("r_rdata1", rdata1, 0);
        check("r_rom_addr", rom_addr, 0);
        rready0 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        req1 = 1'b1; addr1 = 3'h2;
        step();
        check("r_gnt1", gnt1, 1);
        check("r_gnt0", gnt0, 0);
        req1 = 1'b0;
        step();
        check("r_rdata1_new", rdata1, 16'h3C22);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
